ahb_arbiter_slave_param: RTL and testbench
==========================================

AHB_ARBITER_SLAVE_PARAM -- requirements
Module: ahb_arbiter_slave_param

Interface
REQ-001 Parameter MASTER_NUM, default 4: number of requesting masters, legal 2..16.
REQ-002 Parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-003 Parameter MIDX_W, default $clog2(MASTER_NUM): width of the master-index output.
REQ-004 hclk  input  1  bus clock; all state updates on rising edge.
REQ-005 hreset_n  input  1  asynchronous, active-low reset.
REQ-006 hreq  input  MASTER_NUM  per-master bus request.
REQ-007 hburst  input  MASTER_NUM x 3  per-master AHB HBURST code: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
REQ-008 hlock  input  MASTER_NUM  per-master lock; holds ownership across burst boundaries.
REQ-009 hwait  input  1  slave wait; a beat is accepted in any cycle where hsel=1 and hwait=0.
REQ-010 hgrant  output  MASTER_NUM  one-hot grant to masters, equal to grant_reg AND NOT hwait.
REQ-011 hsel  output  1  slave select, equal to OR of grant_reg.
REQ-012 hmaster  output  MIDX_W  binary index of the current owner; 0 when there is no owner.
REQ-013 hlast  output  1  high during the final beat of a fixed-length burst.

Function
REQ-014 grant_reg: registered one-hot owner; never more than one bit set.
REQ-015 FSM states: IDLE (no owner), BURST (fixed-length burst, counting beats), HOLD (SINGLE/INCR owner, or locked owner).
REQ-016 Arbitration: evaluated combinationally in IDLE, and in BURST/HOLD on the release cycle; winner loaded into grant_reg at the next edge (one-cycle latency, req to hsel).
REQ-017 ARB_MODE=0: winner = lowest-index asserted hreq.
REQ-018 ARB_MODE=1: search starts at rr_ptr+1 and wraps modulo MASTER_NUM; rr_ptr loads the winner index whenever a grant is issued.
REQ-019 On grant, the winner's hburst is latched; burst length is 4/8/16 for WRAPn/INCRn (state BURST), otherwise state HOLD.
REQ-020 Beat counter: 4 bits; cleared on grant; increments only on an accepted beat; frozen while hwait=1.
REQ-021 BURST release: an accepted beat with count==len-1 and hlock[owner]=0 triggers re-arbitration in the same cycle.
REQ-022 HOLD release: hreq[owner]=0 and hlock[owner]=0 triggers re-arbitration; the owner is ineligible in that cycle.
REQ-023 The owner dropping hreq mid-BURST does not end the burst; ownership holds until the final beat.
REQ-024 Locked owner at burst end: remains owner, counter clears, latched hburst re-samples, no rr_ptr change.
REQ-025 Release with no requests pending: grant_reg goes to 0 at the next edge and the FSM enters IDLE.
REQ-026 Release with the owner still requesting: in RR mode, other requesters win first; if the owner is the sole requester, re-grant is back-to-back with no idle cycle.
REQ-027 hlast = (state==BURST) AND (count==len-1); it is 0 in HOLD and IDLE.
REQ-028 Out-of-range hburst codes do not occur by construction; the block decodes all 8 codes exhaustively.

Reset
REQ-029 While hreset_n=0: grant_reg=0, hgrant=0, hsel=0, hmaster=0, hlast=0, state IDLE, count=0, rr_ptr=MASTER_NUM-1 (master 0 wins first in RR mode).
REQ-030 Reset asserted mid-burst aborts the burst immediately (asynchronous); on the first edge after deassertion the block arbitrates from IDLE.

Verification
REQ-031 RR, MASTER_NUM=4, hreq=4'b1111, all INCR4, hwait=0 -> owners 0,1,2,3,0; each owns 4 cycles; hlast high on the 4th cycle of each; no gaps.
REQ-032 Fixed mode, hreq=4'b0110, SINGLE, owner 1 drops hreq after 1 beat -> grant 1 then grant 1 again while requested; master 2 wins only after hreq[1]=0.
REQ-033 INCR8 with hwait=1 on beats 3 and 5 -> count freezes on those cycles; burst spans 10 cycles; hlast asserts once, on the accepted 8th beat.
REQ-034 hlock[2]=1 across two WRAP4 bursts while hreq[0]=1 -> master 2 keeps ownership for 8 beats; master 0 is granted on the cycle after lock drops at a boundary.
REQ-035 hreset_n pulsed low during beat 2 of INCR16 -> all outputs 0 asynchronously; after release with hreq=4'b1000, hsel rises one cycle later and hmaster=3.

Source files
------------

// File: rtl/ahb_arbiter_slave_param.sv
// ahb_arbiter_slave_param
//   Grants a single AHB slave to one of MASTER_NUM masters and tracks burst
//   beats so ownership is released only at burst boundaries.
//   Arbitration is either fixed priority (ARB_MODE=0, lowest index wins) or
//   round robin (ARB_MODE=1, search starts one past the last winner).
//
// Ports
//   hclk      in   bus clock
//   hreset_n  in   async active-low reset
//   hreq      in   [MASTER_NUM]    per-master request
//   hburst    in   [MASTER_NUM][3] per-master HBURST code
//   hlock     in   [MASTER_NUM]    per-master lock (hold across bursts)
//   hwait     in   slave wait, beat accepted when hsel & ~hwait
//   hgrant    out  [MASTER_NUM]    one-hot grant, masked by hwait
//   hsel      out  slave select (any owner)
//   hmaster   out  [MIDX_W]        owner index, 0 when no owner
//   hlast     out  final beat of a fixed-length burst
module ahb_arbiter_slave_param #(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 1,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                       hclk,
  input  logic                       hreset_n,
  input  logic [MASTER_NUM-1:0]      hreq,
  input  logic [MASTER_NUM-1:0][2:0] hburst,
  input  logic [MASTER_NUM-1:0]      hlock,
  input  logic                       hwait,
  output logic [MASTER_NUM-1:0]      hgrant,
  output logic                       hsel,
  output logic [MIDX_W-1:0]          hmaster,
  output logic                       hlast
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_HOLD} state_e;

  // Final-beat count for a burst code; 0 marks SINGLE/INCR (no fixed length).
  function automatic logic [3:0] len_m1(input logic [2:0] code);
    case (code)
      3'd2, 3'd3: len_m1 = 4'd3;
      3'd4, 3'd5: len_m1 = 4'd7;
      3'd6, 3'd7: len_m1 = 4'd15;
      default:    len_m1 = 4'd0;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [MASTER_NUM-1:0]  grant_q, grant_d;
  logic [2:0]             burst_q, burst_d;
  logic [3:0]             cnt_q,   cnt_d;
  logic [MIDX_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [MIDX_W-1:0]      owner;
  logic                   lock_own, req_own, accept, arb;
  logic [MASTER_NUM-1:0]  elig;
  logic                   win_vld;
  logic [MIDX_W-1:0]      win_idx;
  logic [MIDX_W-1:0]      jidx;

  // Owner index from the one-hot grant (OR-reduce, grant is never multi-hot).
  always_comb begin
    owner = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (grant_q[i]) owner = owner | MIDX_W'(i);
  end

  assign lock_own = |(grant_q & hlock);
  assign req_own  = |(grant_q & hreq);
  assign accept   = (|grant_q) & ~hwait;

  // Winner search. In HOLD the release only happens once the owner has
  // dropped its request; masking it keeps the owner out explicitly.
  always_comb begin
    elig    = (state_q == S_HOLD) ? (hreq & ~grant_q) : hreq;
    win_vld = 1'b0;
    win_idx = '0;
    jidx    = '0;
    if (ARB_MODE == 0) begin
      for (int i = MASTER_NUM - 1; i >= 0; i--)
        if (elig[i]) begin
          win_vld = 1'b1;
          win_idx = MIDX_W'(i);
        end
    end else begin
      // Walk offsets from far to near so the nearest requester after rr_ptr
      // is the last assignment and therefore the winner.
      for (int k = MASTER_NUM; k >= 1; k--) begin
        jidx = MIDX_W'((int'(rr_ptr_q) + k) % MASTER_NUM);
        if (elig[jidx]) begin
          win_vld = 1'b1;
          win_idx = jidx;
        end
      end
    end
  end

  // State register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= MIDX_W'(MASTER_NUM - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    arb      = 1'b0;
    case (state_q)
      S_IDLE: arb = 1'b1;
      S_BURST: begin
        if (accept) begin
          if (cnt_q == len_m1(burst_q)) begin
            if (lock_own) begin
              // Locked owner rolls into a fresh burst; rr_ptr untouched.
              cnt_d   = '0;
              burst_d = hburst[owner];
              state_d = (len_m1(hburst[owner]) != 4'd0) ? S_BURST : S_HOLD;
            end else begin
              arb = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_HOLD:  if (!req_own && !lock_own) arb = 1'b1;
      default: arb = 1'b1;
    endcase

    if (arb) begin
      cnt_d   = '0;
      grant_d = '0;
      if (win_vld) begin
        grant_d[win_idx] = 1'b1;
        burst_d  = hburst[win_idx];
        state_d  = (len_m1(hburst[win_idx]) != 4'd0) ? S_BURST : S_HOLD;
        rr_ptr_d = win_idx;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Outputs
  always_comb begin
    hgrant  = grant_q & {MASTER_NUM{~hwait}};
    hsel    = |grant_q;
    hmaster = owner;
    hlast   = (state_q == S_BURST) && (cnt_q == len_m1(burst_q));
  end

endmodule

// File: tb/tb_ahb_arbiter_slave_param.sv
module tb_ahb_arbiter_slave_param;

  logic              hclk = 1'b0;
  logic              hreset_n;
  logic [3:0]        hreq;
  logic [3:0][2:0]   hburst;
  logic [3:0]        hlock;
  logic              hwait;

  logic [3:0] rr_gnt, fx_gnt;
  logic       rr_sel, fx_sel, rr_last, fx_last;
  logic [1:0] rr_mst, fx_mst;

  always #5 hclk = ~hclk;

  ahb_arbiter_slave_param #(.MASTER_NUM(4), .ARB_MODE(1)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hlock(hlock), .hwait(hwait), .hgrant(rr_gnt), .hsel(rr_sel),
    .hmaster(rr_mst), .hlast(rr_last));

  ahb_arbiter_slave_param #(.MASTER_NUM(4), .ARB_MODE(0)) u_fx (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
    .hlock(hlock), .hwait(hwait), .hgrant(fx_gnt), .hsel(fx_sel),
    .hmaster(fx_mst), .hlast(fx_last));

  localparam bit RR = 1'b0;
  localparam bit FX = 1'b1;

  // Expected {hgrant, hsel, hmaster, hlast} for one cycle of one DUT.
  typedef struct {
    bit         d;
    string      nm;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] act;
  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.d ? {fx_gnt, fx_sel, fx_mst, fx_last} : {rr_gnt, rr_sel, rr_mst, rr_last};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got gnt/sel/mst/last=%b want %b", e.nm, act, e.exp);
      end
    end
  end

  // One bus cycle: drive inputs just after the edge and queue the outputs
  // expected for this same cycle.
  task automatic cyc(input bit rst, input logic [3:0] rq, input logic [11:0] bu,
                     input logic [3:0] lk, input bit wt, input bit d, input string nm,
                     input logic [3:0] g, input bit s, input logic [1:0] m, input bit l);
    exp_t x;
    @(posedge hclk);
    #1;
    hreset_n = rst;
    hreq     = rq;
    hburst   = bu;
    hlock    = lk;
    hwait    = wt;
    x.d   = d;
    x.nm  = nm;
    x.exp = {g, s, m, l};
    sb.push_back(x);
  endtask

  initial begin
    bit [9:0] wpat;
    int m;
    hreset_n = 1'b1; hreq = '0; hburst = '0; hlock = '0; hwait = 1'b0;
    #2 hreset_n = 1'b0;

    // Reset state, then RR all-INCR4 rotation with no gaps.
    cyc(0, 4'h0, 12'o0000, 4'h0, 0, RR, "reset", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'hf, 12'o3333, 4'h0, 0, RR, "rr idle", 4'h0, 0, 2'd0, 0);
    for (int o = 0; o < 5; o++)
      for (int b = 0; b < 4; b++) begin
        m = o % 4;
        // After the 5th grant everyone drops hreq; the burst must still finish.
        cyc(1, (o == 4 && b > 0) ? 4'h0 : 4'hf, 12'o3333, 4'h0, 0, RR,
            $sformatf("rr o%0d b%0d", o, b), 4'(1 << m), 1, 2'(m), b == 3);
      end
    cyc(1, 4'h0, 12'o3333, 4'h0, 0, RR, "rr empty idle", 4'h0, 0, 2'd0, 0);

    // INCR8 on master 2 with waits on beats 3 and 5.
    cyc(1, 4'b0100, 12'o0500, 4'h0, 0, RR, "i8 arb", 4'h0, 0, 2'd0, 0);
    wpat = 10'b00_0010_0100;
    for (int k = 0; k < 10; k++)
      cyc(1, 4'b0100, 12'o0500, 4'h0, wpat[k], RR, $sformatf("i8 c%0d", k),
          wpat[k] ? 4'h0 : 4'b0100, 1, 2'd2, k == 9);
    cyc(1, 4'b0100, 12'o0500, 4'h0, 0, RR, "i8 regrant", 4'b0100, 1, 2'd2, 0);
    cyc(0, 4'b0100, 12'o0500, 4'h0, 0, RR, "i8 async rst", 4'h0, 0, 2'd0, 0);

    // Locked WRAP4 x2 on master 2 while master 0 waits.
    cyc(1, 4'b0100, 12'o0200, 4'b0100, 0, RR, "lk arb", 4'h0, 0, 2'd0, 0);
    for (int k = 0; k < 8; k++)
      cyc(1, 4'b0101, 12'o0200, (k == 7) ? 4'h0 : 4'b0100, 0, RR,
          $sformatf("lk b%0d", k), 4'b0100, 1, 2'd2, (k == 3) || (k == 7));
    cyc(1, 4'h0, 12'o0200, 4'h0, 0, RR, "lk m0 grant", 4'b0001, 1, 2'd0, 0);
    cyc(1, 4'h0, 12'o0200, 4'h0, 0, RR, "lk idle", 4'h0, 0, 2'd0, 0);

    // INCR16 on master 3 with reset pulsed during beat 2.
    cyc(1, 4'b1000, 12'o7000, 4'h0, 0, RR, "i16 arb", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'b1000, 12'o7000, 4'h0, 0, RR, "i16 b1", 4'b1000, 1, 2'd3, 0);
    cyc(0, 4'b1000, 12'o7000, 4'h0, 0, RR, "i16 rst async", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'b1000, 12'o7000, 4'h0, 0, RR, "i16 rst release", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'b1000, 12'o7000, 4'h0, 0, RR, "i16 regrant", 4'b1000, 1, 2'd3, 0);
    cyc(0, 4'h0, 12'o0000, 4'h0, 0, FX, "fx reset", 4'h0, 0, 2'd0, 0);

    // Fixed priority, SINGLE bursts.
    cyc(1, 4'b0110, 12'o0000, 4'h0, 0, FX, "fx idle", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'b0110, 12'o0000, 4'h0, 0, FX, "fx m1", 4'b0010, 1, 2'd1, 0);
    cyc(1, 4'b0100, 12'o0000, 4'h0, 1, FX, "fx m1 wait", 4'h0, 1, 2'd1, 0);
    cyc(1, 4'h0, 12'o0000, 4'h0, 0, FX, "fx m2", 4'b0100, 1, 2'd2, 0);
    cyc(1, 4'b1010, 12'o0000, 4'h0, 0, FX, "fx idle2", 4'h0, 0, 2'd0, 0);
    cyc(1, 4'b1000, 12'o0000, 4'h0, 0, FX, "fx low wins", 4'b0010, 1, 2'd1, 0);
    cyc(1, 4'h0, 12'o0000, 4'h0, 0, FX, "fx m3", 4'b1000, 1, 2'd3, 0);
    cyc(1, 4'h0, 12'o0000, 4'h0, 0, FX, "fx idle3", 4'h0, 0, 2'd0, 0);

    repeat (2) @(posedge hclk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1);
  end

endmodule
